// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-lite slave-side bus bundle for ahb_lite_mem_slave.
interface ahb_lite_mem_slave_if;
  logic        HSel;
  logic [31:0] SAddress;
  logic [1:0]  STrans;
  logic        SWrite;
  logic [2:0]  SBurst_Size;
  logic [31:0] SWData;
  logic [3:0]  SWStrb;
  logic        HReady;
  logic        HReadyOut;
  logic [1:0]  S_HResp;
  logic [31:0] SRData;

  modport master (
    output HSel, SAddress, STrans, SWrite, SBurst_Size, SWData, SWStrb, HReady,
    input  HReadyOut, S_HResp, SRData
  );

  modport slave (
    input  HSel, SAddress, STrans, SWrite, SBurst_Size, SWData, SWStrb, HReady,
    output HReadyOut, S_HResp, SRData
  );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: word-organised AHB-lite RAM responder with programmable
// wait states, byte-strobed writes and two-cycle ERROR responses.
//
// state | meaning
// IDLE  | no data phase in progress, ready for an address phase
// WAIT  | OKAY data phase, HReadyOut held low while the wait counter runs
// LAST  | final OKAY cycle: read data driven, write commits on the closing edge
// ERR1  | first ERROR cycle, HReadyOut low
// ERR2  | second ERROR cycle, HReadyOut high, next transfer may be accepted
module ahb_lite_mem_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic                 clk,
  input logic                 rst,
  ahb_lite_mem_slave_if.slave bus
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          write_q, write_d;

  logic [31:0]   mem_q [DEPTH];

  logic          accept;
  logic          xfer_err;
  logic          mem_we;
  logic          hready_out;
  logic [1:0]    resp;
  logic [31:0]   rdata;

  // STrans[0] only distinguishes SEQ from NONSEQ and BUSY from IDLE; neither
  // distinction changes how this memory responds.
  logic          unused_strans0;
  assign unused_strans0 = bus.STrans[0];

  // Address-phase acceptance and legality decode of the offered transfer.
  always_comb begin
    accept   = bus.HSel & bus.HReady & bus.STrans[1];
    xfer_err = 1'b0;
    if (bus.SBurst_Size > 3'd2) xfer_err = 1'b1;
    if (bus.SBurst_Size == 3'd1 && bus.SAddress[0]) xfer_err = 1'b1;
    if (bus.SBurst_Size == 3'd2 && bus.SAddress[1:0] != 2'b00) xfer_err = 1'b1;
    if (bus.SAddress[31:2] >= 30'(DEPTH)) xfer_err = 1'b1;
  end

  // Next-state, data-phase register and output decode.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    hready_out = 1'b1;
    resp       = RESP_OKAY;
    mem_we     = 1'b0;
    rdata      = '0;

    case (state_q)
      S_WAIT: begin
        hready_out = 1'b0;
        if (wait_cnt_q <= 4'd1) begin
          state_d    = S_LAST;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_LAST: begin
        if (write_q) mem_we = 1'b1;
        else         rdata  = mem_q[idx_q];
        state_d = S_IDLE;
      end
      S_ERR1: begin
        hready_out = 1'b0;
        resp       = RESP_ERROR;
        state_d    = S_ERR2;
      end
      S_ERR2: begin
        resp    = RESP_ERROR;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new transfer can start wherever HReadyOut is high: IDLE, LAST, ERR2.
    if (accept && (state_q == S_IDLE || state_q == S_LAST || state_q == S_ERR2)) begin
      if (xfer_err) begin
        state_d = S_ERR1;
      end else begin
        idx_d   = bus.SAddress[AW+1:2];
        write_d = bus.SWrite;
        if (WAIT_STATES > 0) begin
          state_d    = S_WAIT;
          wait_cnt_d = 4'(WAIT_STATES);
        end else begin
          state_d = S_LAST;
        end
      end
    end
  end

  // State and data-phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
    end
  end

  // Byte-lane write port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.SWStrb[b]) mem_q[idx_q][8*b +: 8] <= bus.SWData[8*b +: 8];
      end
    end
  end

  assign bus.HReadyOut = hready_out;
  assign bus.S_HResp   = resp;
  assign bus.SRData    = rdata;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: one instance with no wait states and one with
// three, driven by a pipelined master; a reference memory predicts responses.
module tb_ahb_lite_mem_slave;
  localparam int DEPTH = 64;
  localparam int WS_B  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ahb_lite_mem_slave_if bus0();
  ahb_lite_mem_slave_if bus3();

  logic        sel = 1'b0;
  logic        m_hsel = 1'b0;
  logic [31:0] m_addr = '0;
  logic [1:0]  m_trans = 2'b00;
  logic        m_write = 1'b0;
  logic [2:0]  m_size = 3'd0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_strb = '0;
  logic        hready_force_low = 1'b0;

  logic        hro;
  logic [1:0]  resp;
  logic [31:0] rdata;
  logic        hready_in;

  assign hro       = sel ? bus3.HReadyOut : bus0.HReadyOut;
  assign resp      = sel ? bus3.S_HResp   : bus0.S_HResp;
  assign rdata     = sel ? bus3.SRData    : bus0.SRData;
  assign hready_in = hro & ~hready_force_low;

  assign bus0.HSel = m_hsel & ~sel;
  assign bus3.HSel = m_hsel & sel;
  assign bus0.SAddress = m_addr;      assign bus3.SAddress = m_addr;
  assign bus0.STrans = m_trans;       assign bus3.STrans = m_trans;
  assign bus0.SWrite = m_write;       assign bus3.SWrite = m_write;
  assign bus0.SBurst_Size = m_size;   assign bus3.SBurst_Size = m_size;
  assign bus0.SWData = m_wdata;       assign bus3.SWData = m_wdata;
  assign bus0.SWStrb = m_strb;        assign bus3.SWStrb = m_strb;
  assign bus0.HReady = hready_in;     assign bus3.HReady = hready_in;

  ahb_lite_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  ahb_lite_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS_B)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  typedef struct {
    logic        hsel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
    int          waits;
  } resp_t;

  resp_t       sb_q[$];
  xfer_t       seq_q[$];
  logic [31:0] model [2][DEPTH];

  int total = 0;
  int bad   = 0;
  int low_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [2:0] sz,
                               input logic [31:0] d, input logic [3:0] st, input logic [1:0] tr);
    xfer_t x;
    x.hsel = 1'b1; x.addr = a; x.write = w; x.size = sz;
    x.wdata = d; x.strb = st; x.trans = tr;
    return x;
  endfunction

  // Reference memory: decides legality from the bus rules and applies writes
  // in issue order, so a read always sees every earlier write.
  function automatic void predict(input xfer_t x);
    resp_t e;
    int s, w;
    bit err;
    s = sel ? 1 : 0;
    err = (x.size > 3'd2);
    if (!err && (x.addr % (32'd1 << x.size)) != 0) err = 1'b1;
    if ((x.addr / 4) >= DEPTH) err = 1'b1;
    e.err   = err;
    e.rd    = !err && !x.write;
    e.waits = err ? 1 : (s == 1 ? WS_B : 0);
    e.data  = '0;
    if (!err) begin
      w = int'(x.addr / 4);
      if (x.write) begin
        for (int b = 0; b < 4; b++)
          if (x.strb[b]) model[s][w][8*b +: 8] = x.wdata[8*b +: 8];
      end else begin
        e.data = model[s][w];
      end
    end
    sb_q.push_back(e);
  endfunction

  task automatic drive_idle();
    m_hsel = 1'b0; m_addr = '0; m_trans = 2'b00; m_write = 1'b0; m_size = 3'd0;
  endtask

  // Pipelined master: address phase of the next item overlaps the data phase
  // of the previous one; each item advances only when HReady is high.
  task automatic run_seq();
    logic [31:0] dp_wdata;
    logic [3:0]  dp_strb;
    xfer_t x;
    int guard;
    logic rdy;
    dp_wdata = '0; dp_strb = '0; guard = 0;
    forever begin
      if (seq_q.size() > 0) begin
        m_hsel = seq_q[0].hsel; m_addr = seq_q[0].addr; m_trans = seq_q[0].trans;
        m_write = seq_q[0].write; m_size = seq_q[0].size;
      end else begin
        drive_idle();
      end
      m_wdata = dp_wdata; m_strb = dp_strb;
      @(negedge clk);
      rdy = hready_in;
      @(posedge clk);
      #1;
      if (rdy) begin
        guard = 0;
        if (seq_q.size() == 0) break;
        x = seq_q.pop_front();
        if (x.hsel && x.trans[1]) predict(x);
        dp_wdata = x.wdata; dp_strb = x.strb;
      end else begin
        guard++;
        if (guard > 40) begin
          total++; bad++;
          $display("FAIL hready_timeout: HReadyOut stuck low, expected high within 40 cycles");
          seq_q.delete();
          break;
        end
      end
    end
    drive_idle();
  endtask

  // Monitor: tracks data phases from the bus, pops the expected response when
  // the selected slave completes one, and checks idle outputs otherwise.
  bit dp_active = 1'b0;
  int dp_waits  = 0;
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      dp_active = 1'b0;
      dp_waits  = 0;
      sb_q.delete();
    end else begin
      if (!hro) low_cnt++;
      if (dp_active) begin
        if (!hro) begin
          dp_waits++;
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: data phase stalled with no expected response");
          end else begin
            check("wait_resp", 64'(resp), sb_q[0].err ? 64'd1 : 64'd0);
            check("wait_rdata", 64'(rdata), 64'd0);
          end
        end else begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: data phase completed with no expected response");
          end else begin
            e = sb_q.pop_front();
            check("waits", 64'(dp_waits), 64'(e.waits));
            check("resp", 64'(resp), e.err ? 64'd1 : 64'd0);
            check("rdata", 64'(rdata), e.rd ? 64'(e.data) : 64'd0);
          end
          dp_active = 1'b0;
        end
      end else begin
        check("idle_out", {31'd0, hro, resp, rdata}, {31'd0, 1'b1, 2'b00, 32'd0});
      end
      if (!dp_active && hready_in && m_hsel && m_trans[1]) begin
        dp_active = 1'b1;
        dp_waits  = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_low;
    xfer_t x;
    int word, off, r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_dut0", {bus0.HReadyOut, bus0.S_HResp, bus0.SRData}, {1'b1, 2'b00, 32'd0});
    check("rst_out_dut3", {bus3.HReadyOut, bus3.S_HResp, bus3.SRData}, {1'b1, 2'b00, 32'd0});
    rst = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 32; i++) seq_q.push_back(mk(32'(i*4), 1'b1, 3'd2, $urandom, 4'hF, 2'b10));
      run_seq();
    end

    sel = 1'b0;
    seq_q.push_back(mk(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF, 2'b10));
    seq_q.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
    run_seq();

    sel = 1'b1;
    seq_q.push_back(mk(32'h04, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
    seq_q.push_back(mk(32'h04, 1'b1, 3'd2, 32'h5A5A1234, 4'hF, 2'b10));
    seq_q.push_back(mk(32'h04, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
    run_seq();

    sel = 1'b0;
    seq_q.push_back(mk(32'h20, 1'b1, 3'd2, 32'h11223344, 4'hF, 2'b10));
    seq_q.push_back(mk(32'h20, 1'b1, 3'd2, 32'hAABBCCDD, 4'b0101, 2'b10));
    seq_q.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
    run_seq();

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      seq_q.push_back(mk(32'h22, 1'b1, 3'd2, $urandom, 4'hF, 2'b10));
      seq_q.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
      seq_q.push_back(mk(32'h08, 1'b1, 3'd3, $urandom, 4'hF, 2'b10));
      seq_q.push_back(mk(32'h08, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
      seq_q.push_back(mk(32'(DEPTH*4), 1'b1, 3'd2, $urandom, 4'hF, 2'b10));
      seq_q.push_back(mk(32'h00, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
      run_seq();
    end

    sel = 1'b0;
    base_low = low_cnt;
    for (int i = 0; i < 8; i++)
      seq_q.push_back(mk(32'(32'h40 + i*4), 1'b1, 3'd2, $urandom, 4'hF, (i == 0) ? 2'b10 : 2'b11));
    seq_q.push_back(mk(32'h5C, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
    for (int i = 0; i < 7; i++)
      seq_q.push_back(mk(32'(32'h40 + i*4), 1'b0, 3'd2, 32'h0, 4'h0, 2'b11));
    run_seq();
    check("burst_no_stall", 64'(low_cnt - base_low), 64'd0);

    hready_force_low = 1'b1;
    m_hsel = 1'b1; m_addr = 32'h10; m_trans = 2'b10; m_write = 1'b1; m_size = 3'd2;
    m_wdata = 32'h0BADF00D; m_strb = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    drive_idle();
    hready_force_low = 1'b0;
    @(posedge clk); #1;
    seq_q.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
    run_seq();

    sel = 1'b1;
    m_hsel = 1'b1; m_addr = 32'h30; m_trans = 2'b10; m_write = 1'b1; m_size = 3'd2;
    @(negedge clk);
    @(posedge clk); #1;
    drive_idle();
    m_wdata = 32'hCAFEF00D; m_strb = 4'hF;
    check("rst_mid_stalled", 64'(hro), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_out", {hro, resp, rdata}, {1'b1, 2'b00, 32'd0});
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    seq_q.push_back(mk(32'h30, 1'b0, 3'd2, 32'h0, 4'h0, 2'b10));
    run_seq();

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 80; i++) begin
        x.hsel  = ($urandom_range(0, 9) != 0);
        r       = $urandom_range(0, 9);
        x.trans = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        x.write = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        word    = $urandom_range(0, 31);
        off     = $urandom_range(0, 3);
        if (x.size <= 3'd2) off = off & ~((1 << x.size) - 1);
        r = $urandom_range(0, 14);
        if (r == 0) off = $urandom_range(0, 3);
        if (r == 1) word = DEPTH + $urandom_range(0, 100);
        x.addr  = 32'(word * 4 + off);
        x.wdata = $urandom;
        x.strb  = 4'($urandom_range(0, 15));
        seq_q.push_back(x);
      end
      run_seq();
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
